// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with an optional two-entry skid buffer
// (registered in_ready) and a synchronous flush for bubble insertion.
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  generate
    if (SKID) begin : g_skid
      state_t           state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             in_ready_q, in_ready_d;
      logic             in_fire, out_fire;

      assign in_fire  = in_valid & in_ready_q;
      assign out_fire = (state_q != EMPTY) & out_ready;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              state_d = ONE;
              main_d  = in_data;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_d = in_data;
            end else if (in_fire) begin
              state_d = FULL;
              skid_d  = in_data;
            end else if (out_fire) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
        // Flush drops everything held; data registers keep their old contents.
        if (flush) begin
          state_d = EMPTY;
          main_d  = main_q;
          skid_d  = skid_q;
        end
        in_ready_d = (state_d != FULL);
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q    <= EMPTY;
          main_q     <= '0;
          skid_q     <= '0;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready  = in_ready_q;
      assign out_valid = (state_q != EMPTY);
      assign out_data  = main_q;
      assign occupancy = state_q;
    end else begin : g_single
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic             in_fire, out_fire;

      assign in_ready = !valid_q | out_ready;
      assign in_fire  = in_valid & in_ready;
      assign out_fire = valid_q & out_ready;

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (in_fire) begin
          valid_d = 1'b1;
          main_d  = in_data;
        end else if (out_fire) begin
          valid_d = 1'b0;
        end
        if (flush) begin
          valid_d = 1'b0;
          main_d  = main_q;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign out_valid = valid_q;
      assign out_data  = main_q;
      assign occupancy = {1'b0, valid_q};
    end
  endgenerate

endmodule
